// File: rtl/router_pkt_tx_if.sv
// ---------------------------------------------------------------------------
// router_pkt_tx_if
// Bundles the payload-source handshake and the router-side packet bus of the
// router_pkt_tx packet source.
//
// Signals:
//   start, dest_addr, pay_len   request pulse and packet fields
//   pay_data, pay_valid         payload bytes from the upstream source
//   pay_ready                   packet source accepts pay_data this cycle
//   busy                        router back-pressure
//   data_out, pkt_valid         byte stream to the router input port
//   tx_active, done, req_err    status
//   corrupt_par                 parity-corruption request (only when the
//                               ROUTER_TX_PARITY_INJ_EN macro is defined)
//
// Modports:
//   master  the packet source (router_pkt_tx)
//   slave   the environment: upstream source plus router
// ---------------------------------------------------------------------------
interface router_pkt_tx_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
);
    logic              start;
    logic [1:0]        dest_addr;
    logic [LEN_W-1:0]  pay_len;
    logic [DATA_W-1:0] pay_data;
    logic              pay_valid;
    logic              pay_ready;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              pkt_valid;
    logic              tx_active;
    logic              done;
    logic              req_err;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic              corrupt_par;

    modport master (
        input  start, dest_addr, pay_len, pay_data, pay_valid, busy, corrupt_par,
        output pay_ready, data_out, pkt_valid, tx_active, done, req_err
    );

    modport slave (
        output start, dest_addr, pay_len, pay_data, pay_valid, busy, corrupt_par,
        input  pay_ready, data_out, pkt_valid, tx_active, done, req_err
    );
`else
    modport master (
        input  start, dest_addr, pay_len, pay_data, pay_valid, busy,
        output pay_ready, data_out, pkt_valid, tx_active, done, req_err
    );

    modport slave (
        output start, dest_addr, pay_len, pay_data, pay_valid, busy,
        input  pay_ready, data_out, pkt_valid, tx_active, done, req_err
    );
`endif
endinterface

// File: rtl/router_pkt_tx.sv
// ---------------------------------------------------------------------------
// router_pkt_tx
// Packet source for one input port of the 1x3 router. On a legal request it
// collects the whole payload into an internal buffer, then streams
//   header {pay_len, dest_addr}, pay_len payload bytes, parity byte
// with pkt_valid held high and contiguous for header and payload, and low on
// the parity beat. Parity is the XOR of the header and all payload bytes.
//
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous, active-high
//   bus     router_pkt_tx_if.master: request fields, payload handshake,
//           router data/back-pressure, status pulses
//
// Build option:
//   ROUTER_TX_PARITY_INJ_EN  adds corrupt_par; when set with start, bit 0 of
//                            the transmitted parity byte is inverted (the
//                            internal parity register stays correct).
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; checks request fields
// LOAD    | accepting payload bytes into the buffer
// HEADER  | header on data_out, waiting for busy=0
// PAYLOAD | payload byte on data_out, waiting for busy=0
// PARITY  | parity byte on data_out (pkt_valid=0), waiting for busy=0
// DONE    | done pulse, back to IDLE next cycle
// ---------------------------------------------------------------------------
module router_pkt_tx #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic            clock,
    input  logic            reset,
    router_pkt_tx_if.master bus
);
    localparam int DEPTH = (2 ** LEN_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_DONE
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        dest_q;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] parity;
    logic [DATA_W-1:0] data_out_q;
    logic              pkt_valid_q;
    logic              tx_active_q;
    logic              done_q;
    logic              req_err_q;
    logic              corrupt_q;

    logic [DATA_W-1:0] buffer [DEPTH];

    logic              wr_en;
    logic              req_bad;
    logic [LEN_W-1:0]  count_inc;
    logic [LEN_W-1:0]  rd_ptr_inc;
    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] par_out;

    assign bus.pay_ready = (state == S_LOAD) && (count < len_q);
    assign wr_en         = bus.pay_valid && bus.pay_ready;
    assign req_bad       = (bus.dest_addr == 2'd3) || (bus.pay_len == '0);
    assign count_inc     = count + LEN_W'(1);
    assign rd_ptr_inc    = rd_ptr + LEN_W'(1);
    assign header        = {len_q, dest_q};

    // The parity register always holds the true XOR; corruption is applied
    // only to the byte placed on data_out.
    assign par_out = parity ^ {{(DATA_W-1){1'b0}}, corrupt_q};

`ifdef ROUTER_TX_PARITY_INJ_EN
    logic corrupt_in;
    assign corrupt_in = bus.corrupt_par;
`else
    logic corrupt_in;
    assign corrupt_in = 1'b0;
`endif

    // Payload storage carries no reset: contents are only read after LOAD
    // has rewritten every byte of the current packet.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buffer[count] <= bus.pay_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            len_q       <= '0;
            dest_q      <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            parity      <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
            corrupt_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            req_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (req_bad) begin
                            req_err_q <= 1'b1;
                        end else begin
                            len_q       <= bus.pay_len;
                            dest_q      <= bus.dest_addr;
                            count       <= '0;
                            rd_ptr      <= '0;
                            corrupt_q   <= corrupt_in;
                            tx_active_q <= 1'b1;
                            state       <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (wr_en) begin
                        count <= count_inc;
                        // Header goes out on the same edge that stores the
                        // last payload byte.
                        if (count_inc == len_q) begin
                            data_out_q  <= header;
                            pkt_valid_q <= 1'b1;
                            parity      <= header;
                            state       <= S_HEADER;
                        end
                    end
                end

                S_HEADER: begin
                    if (!bus.busy) begin
                        data_out_q <= buffer[0];
                        parity     <= parity ^ buffer[0];
                        rd_ptr     <= LEN_W'(1);
                        state      <= S_PAYLOAD;
                    end
                end

                S_PAYLOAD: begin
                    // rd_ptr counts bytes already placed on data_out.
                    if (!bus.busy) begin
                        if (rd_ptr == len_q) begin
                            data_out_q  <= par_out;
                            pkt_valid_q <= 1'b0;
                            state       <= S_PARITY;
                        end else begin
                            data_out_q <= buffer[rd_ptr];
                            parity     <= parity ^ buffer[rd_ptr];
                            rd_ptr     <= rd_ptr_inc;
                        end
                    end
                end

                S_PARITY: begin
                    if (!bus.busy) begin
                        data_out_q <= '0;
                        done_q     <= 1'b1;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    tx_active_q <= 1'b0;
                    state       <= S_IDLE;
                end

                default: begin
                    data_out_q  <= '0;
                    pkt_valid_q <= 1'b0;
                    tx_active_q <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.tx_active = tx_active_q;
    assign bus.done      = done_q;
    assign bus.req_err   = req_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_tx
// Directed bench for router_pkt_tx. Inputs are driven and outputs sampled on
// the falling clock edge. Expected bytes are hand-computed constants or XORs
// of the bench's own payload tables.
// ---------------------------------------------------------------------------
module tb_router_pkt_tx;
    logic clock = 1'b0;
    logic reset = 1'b0;

    router_pkt_tx_if bus ();

    router_pkt_tx dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] pay_buf  [64];
    logic [7:0] obs_d    [128];
    logic       obs_pv   [128];
    logic       obs_done [128];

    // Issue a request; returns at the negedge after start was sampled.
    task automatic issue(input logic [1:0] dest, input logic [5:0] len, input logic corrupt);
        bus.start     = 1'b1;
        bus.dest_addr = dest;
        bus.pay_len   = len;
`ifdef ROUTER_TX_PARITY_INJ_EN
        bus.corrupt_par = corrupt;
`else
        if (corrupt) bus.start = 1'b1;
`endif
        @(negedge clock);
        bus.start = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        bus.corrupt_par = 1'b0;
`endif
    endtask

    // Feed pay_buf[0..len-1]; optional idle cycle between bytes. Returns at
    // the negedge where the header is on data_out. pv_seen reports any
    // pkt_valid seen before the final byte was offered.
    task automatic load(input int len, input bit gap, output bit pv_seen);
        pv_seen = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (bus.pkt_valid) pv_seen = 1'b1;
            bus.pay_valid = 1'b1;
            bus.pay_data  = pay_buf[i];
            @(negedge clock);
            bus.pay_valid = 1'b0;
            if (gap && i != len - 1) @(negedge clock);
        end
    endtask

    // Record ncyc cycles of router-side outputs; busy_mask[c] is driven for
    // the rising edge following sample c.
    task automatic capture(input int ncyc, input logic [127:0] busy_mask);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clock);
            obs_d[c]    = bus.data_out;
            obs_pv[c]   = bus.pkt_valid;
            obs_done[c] = bus.done;
            bus.busy    = busy_mask[c];
        end
        bus.busy = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.dest_addr = 0; bus.pay_len = 0;
        bus.pay_data = 0; bus.pay_valid = 0; bus.busy = 0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        bus.corrupt_par = 0;
`endif
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.data_out, bus.pkt_valid, bus.pay_ready, bus.tx_active, bus.done, bus.req_err} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data_out=%h pkt_valid=%b pay_ready=%b tx_active=%b done=%b req_err=%b, want all 0",
                     bus.data_out, bus.pkt_valid, bus.pay_ready, bus.tx_active, bus.done, bus.req_err);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bus.busy = 1'b1;
        repeat (3) @(negedge clock);
        bus.busy = 1'b0;
        n_cmp++;
        if ({bus.pkt_valid, bus.pay_ready, bus.tx_active} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got pkt_valid=%b pay_ready=%b tx_active=%b, want 000",
                     bus.pkt_valid, bus.pay_ready, bus.tx_active);
        end
    endtask

    task automatic test_basic();
        bit pv;
        logic [7:0] exp_d [7];
        logic       exp_pv [7];
        logic       exp_dn [7];
        exp_d  = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'h0D ^ 8'hA1 ^ 8'hB2 ^ 8'hC3, 8'h00, 8'h00};
        exp_pv = '{1, 1, 1, 1, 0, 0, 0};
        exp_dn = '{0, 0, 0, 0, 0, 1, 0};
        pay_buf[0] = 8'hA1; pay_buf[1] = 8'hB2; pay_buf[2] = 8'hC3;
        issue(2'd1, 6'd3, 1'b0);
        n_cmp++;
        if (bus.pay_ready !== 1'b1 || bus.tx_active !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_load_entry: got pay_ready=%b tx_active=%b, want 1 1", bus.pay_ready, bus.tx_active);
        end
        load(3, 1'b0, pv);
        n_cmp++;
        if (pv !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pv_during_load: got %b, want 0", pv);
        end
        n_cmp++;
        if (bus.pay_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pay_ready_after_load: got %b, want 0", bus.pay_ready);
        end
        capture(7, '0);
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if (obs_d[c] !== exp_d[c] || obs_pv[c] !== exp_pv[c] || obs_done[c] !== exp_dn[c]) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got data=%h pv=%b done=%b, want data=%h pv=%b done=%b",
                         c, obs_d[c], obs_pv[c], obs_done[c], exp_d[c], exp_pv[c], exp_dn[c]);
            end
        end
        n_cmp++;
        if (bus.tx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_back_idle: got tx_active=%b, want 0", bus.tx_active);
        end
    endtask

    task automatic test_backpressure();
        bit pv;
        logic [7:0] exp_d [10];
        logic       exp_pv [10];
        logic       exp_dn [10];
        logic [7:0] par;
        par    = 8'h0D ^ 8'hA1 ^ 8'hB2 ^ 8'hC3;
        exp_d  = '{8'h0D, 8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hC3, par, par, 8'h00, 8'h00};
        exp_pv = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        exp_dn = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        pay_buf[0] = 8'hA1; pay_buf[1] = 8'hB2; pay_buf[2] = 8'hC3;
        issue(2'd1, 6'd3, 1'b0);
        load(3, 1'b0, pv);
        capture(10, 128'h4C);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (obs_d[c] !== exp_d[c] || obs_pv[c] !== exp_pv[c] || obs_done[c] !== exp_dn[c]) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got data=%h pv=%b done=%b, want data=%h pv=%b done=%b",
                         c, obs_d[c], obs_pv[c], obs_done[c], exp_d[c], exp_pv[c], exp_dn[c]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] dests [2];
        logic [5:0] lens  [2];
        int   extra;
        bit   activity;
        dests = '{2'd3, 2'd0};
        lens  = '{6'd4, 6'd0};
        for (int k = 0; k < 2; k++) begin
            bus.start = 1'b1; bus.dest_addr = dests[k]; bus.pay_len = lens[k];
            bus.pay_valid = 1'b1; bus.pay_data = 8'h77;
            @(negedge clock);
            bus.start = 1'b0;
            n_cmp++;
            if (bus.req_err !== 1'b1 || bus.pay_ready !== 1'b0 || bus.tx_active !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal%0d_response: got req_err=%b pay_ready=%b tx_active=%b, want 1 0 0",
                         k, bus.req_err, bus.pay_ready, bus.tx_active);
            end
            extra = 0; activity = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clock);
                if (bus.req_err) extra++;
                if (bus.pkt_valid || bus.pay_ready || bus.tx_active) activity = 1;
            end
            bus.pay_valid = 1'b0;
            n_cmp++;
            if (extra != 0 || activity) begin
                n_fail++;
                $display("FAIL illegal%0d_quiet: got extra_req_err=%0d activity=%b, want 0 0", k, extra, activity);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit pv;
        bit leak;
        logic [7:0] exp_d [5];
        logic       exp_pv [5];
        logic       exp_dn [5];
        exp_d  = '{8'h06, 8'h5A, 8'h06 ^ 8'h5A, 8'h00, 8'h00};
        exp_pv = '{1, 1, 0, 0, 0};
        exp_dn = '{0, 0, 0, 1, 0};
        pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
        pay_buf[3] = 8'h44; pay_buf[4] = 8'h55;
        issue(2'd0, 6'd5, 1'b0);
        load(5, 1'b0, pv);
        capture(3, '0);
        n_cmp++;
        if (obs_d[2] !== 8'h22 || obs_pv[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got data=%h pv=%b, want 22 1", obs_d[2], obs_pv[2]);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.data_out, bus.pkt_valid, bus.pay_ready, bus.tx_active, bus.done} !== 12'h0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got data_out=%h pkt_valid=%b pay_ready=%b tx_active=%b done=%b, want all 0",
                     bus.data_out, bus.pkt_valid, bus.pay_ready, bus.tx_active, bus.done);
        end
        @(negedge clock);
        reset = 1'b0;
        leak = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (bus.pkt_valid || bus.tx_active || bus.done || bus.data_out != 8'h00) leak = 1;
        end
        n_cmp++;
        if (leak) begin
            n_fail++;
            $display("FAIL rst_mid_no_parity: got activity after reset=1, want 0");
        end
        pay_buf[0] = 8'h5A;
        issue(2'd2, 6'd1, 1'b0);
        load(1, 1'b0, pv);
        capture(5, '0);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (obs_d[c] !== exp_d[c] || obs_pv[c] !== exp_pv[c] || obs_done[c] !== exp_dn[c]) begin
                n_fail++;
                $display("FAIL rst_mid_next_beat%0d: got data=%h pv=%b done=%b, want data=%h pv=%b done=%b",
                         c, obs_d[c], obs_pv[c], obs_done[c], exp_d[c], exp_pv[c], exp_dn[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit pv;
        pay_buf[0] = 8'h3C;
        issue(2'd0, 6'd1, 1'b0);
        load(1, 1'b0, pv);
        capture(4, '0);
        n_cmp++;
        if (obs_d[0] !== 8'h04 || obs_d[2] !== (8'h04 ^ 8'h3C) || obs_pv[2] !== 1'b0 || obs_done[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got hdr=%h par=%h pv=%b done=%b, want 04 38 0 1",
                     obs_d[0], obs_d[2], obs_pv[2], obs_done[3]);
        end
        // Start during DONE must be ignored.
        bus.start = 1'b1; bus.dest_addr = 2'd1; bus.pay_len = 6'd2;
        @(negedge clock);
        n_cmp++;
        if (bus.tx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_start_ignored: got tx_active=%b, want 0", bus.tx_active);
        end
        // Held into the cycle after DONE: earliest accepted start.
        @(negedge clock);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.tx_active !== 1'b1 || bus.pay_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got tx_active=%b pay_ready=%b, want 1 1", bus.tx_active, bus.pay_ready);
        end
        pay_buf[0] = 8'h01; pay_buf[1] = 8'h02;
        load(2, 1'b0, pv);
        capture(6, '0);
        n_cmp++;
        if (obs_d[0] !== 8'h09 || obs_d[1] !== 8'h01 || obs_d[2] !== 8'h02 ||
            obs_d[3] !== (8'h09 ^ 8'h01 ^ 8'h02) || obs_pv[3] !== 1'b0 || obs_done[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got %h %h %h %h pv=%b done=%b, want 09 01 02 0a 0 1",
                     obs_d[0], obs_d[1], obs_d[2], obs_d[3], obs_pv[3], obs_done[4]);
        end
    endtask

    task automatic test_max_len(input logic corrupt);
        bit pv;
        logic [7:0] par;
        par = 8'hFE;
        for (int i = 0; i < 63; i++) begin
            pay_buf[i] = 8'(i * 5 + 7);
            par = par ^ pay_buf[i];
        end
        issue(2'd2, 6'd63, corrupt);
        load(63, 1'b1, pv);
        n_cmp++;
        if (pv !== 1'b0) begin
            n_fail++;
            $display("FAIL max%0d_pv_during_load: got %b, want 0", corrupt, pv);
        end
        capture(67, '0);
        n_cmp++;
        if (obs_d[0] !== 8'hFE || obs_pv[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL max%0d_header: got %h pv=%b, want fe 1", corrupt, obs_d[0], obs_pv[0]);
        end
        for (int c = 1; c <= 63; c++) begin
            n_cmp++;
            if (obs_d[c] !== pay_buf[c-1] || obs_pv[c] !== 1'b1) begin
                n_fail++;
                $display("FAIL max%0d_payload%0d: got %h pv=%b, want %h 1", corrupt, c-1, obs_d[c], obs_pv[c], pay_buf[c-1]);
            end
        end
        n_cmp++;
        if (obs_d[64] !== (par ^ {7'b0, corrupt}) || obs_pv[64] !== 1'b0 || obs_done[65] !== 1'b1) begin
            n_fail++;
            $display("FAIL max%0d_parity: got %h pv=%b done=%b, want %h 0 1",
                     corrupt, obs_d[64], obs_pv[64], obs_done[65], par ^ {7'b0, corrupt});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_max_len(1'b0);
`ifdef ROUTER_TX_PARITY_INJ_EN
        test_max_len(1'b1);
        test_basic();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
